chase_monitor: RTL and testbench

Receive-side checker for the 6-lamp light-chaser bus. Samples the one-hot lamp vector each clock and decodes the lit position. Verifies legal one-hot encoding, rotation order (0→1→…→5→0) and per-step dwell time, and counts completed laps. Sits beside the chaser on the lamp bus as a self-test/observation block, on the chaser's clock.

---
 rtl/chase_pkg.sv | 22 ++
 rtl/chase_onehot_dec.sv | 31 +++
 rtl/chase_monitor.sv | 152 +++++++++++++++
 tb/tb_chase_monitor.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chase_pkg.sv
// Shared definitions for the light-chaser receive-side monitor.
package chase_pkg;

  localparam int unsigned DEF_N_LEDS = 6;
  localparam int unsigned DEF_DWELL  = 4;
  localparam int unsigned DEF_LAP_W  = 8;
  localparam int unsigned POS_W      = 3;

  // SEARCH waits for a clean one-hot sample; TRACK follows the rotation.
  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } state_e;

  // Successor lamp index in rotation order, wrapping after n-1.
  function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] p,
                                                 input int unsigned     n);
    if ((32'(p) + 32'd1) >= n) return POS_W'(0);
    return p + POS_W'(1);
  endfunction

endpackage

// File: rtl/chase_onehot_dec.sv
// Combinational decode of the lamp bus into a legality flag and lit index.
module chase_onehot_dec
  import chase_pkg::*;
#(
  parameter int unsigned N_LEDS = DEF_N_LEDS
) (
  input  logic [N_LEDS:0]  l,
  output logic             is_onehot,
  output logic [POS_W-1:0] idx
);

  logic seen;
  logic multi;

  // Scan active lamps: track whether any and more than one are lit, OR in index.
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    idx   = '0;
    for (int i = 0; i < int'(N_LEDS); i++) begin
      if (l[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        idx  = idx | POS_W'(i);
      end
    end
    // The spare top bit must never be driven by a healthy chaser.
    is_onehot = seen & ~multi & ~l[N_LEDS];
  end

endmodule

// File: rtl/chase_monitor.sv
// Observes the chaser lamp bus: checks encoding, rotation order and dwell,
// and counts completed laps.
module chase_monitor
  import chase_pkg::*;
#(
  parameter int unsigned N_LEDS = DEF_N_LEDS,
  parameter int unsigned DWELL  = DEF_DWELL,
  parameter int unsigned LAP_W  = DEF_LAP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_LEDS:0]  l,
  output logic [POS_W-1:0] pos,
  output logic             locked,
  output logic             step,
  output logic [LAP_W-1:0] lap_count,
  output logic             err_pulse,
  output logic             err_onehot,
  output logic             err_order,
  output logic             err_dwell
);

  // Counter must be able to hold DWELL+1, the stall detection value.
  localparam int unsigned      DCNT_W     = $clog2(DWELL + 2);
  localparam logic [DCNT_W-1:0] DCNT_ONE   = DCNT_W'(1);
  localparam logic [DCNT_W-1:0] DCNT_DWELL = DCNT_W'(DWELL);
  localparam logic [DCNT_W-1:0] DCNT_MAX   = DCNT_W'(DWELL + 1);
  localparam logic [POS_W-1:0]  LAST_POS   = POS_W'(N_LEDS - 1);
  localparam logic [LAP_W-1:0]  LAP_MAX    = {LAP_W{1'b1}};

  state_e              state_q;
  state_e              state_d;
  logic [DCNT_W-1:0]   dcnt_q;
  logic [DCNT_W-1:0]   dcnt_d;
  logic                first_q;
  logic                first_d;
  logic [POS_W-1:0]    pos_d;
  logic [LAP_W-1:0]    lap_d;
  logic                locked_d;
  logic                step_d;
  logic                err_pulse_d;
  logic                err_onehot_d;
  logic                err_order_d;
  logic                err_dwell_d;

  logic                is_onehot;
  logic [POS_W-1:0]    idx;

  chase_onehot_dec #(
    .N_LEDS (N_LEDS)
  ) u_dec (
    .l         (l),
    .is_onehot (is_onehot),
    .idx       (idx)
  );

  // Next-state and next-output decode; everything holds while enable is low.
  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    first_d      = first_q;
    pos_d        = pos;
    lap_d        = lap_count;
    step_d       = 1'b0;
    err_pulse_d  = 1'b0;
    err_onehot_d = err_onehot;
    err_order_d  = err_order;
    err_dwell_d  = err_dwell;

    if (enable) begin
      case (state_q)
        SEARCH: begin
          if (is_onehot) begin
            // Phase of the first lamp is unknown, so its dwell is not judged.
            state_d = TRACK;
            pos_d   = idx;
            dcnt_d  = DCNT_ONE;
            first_d = 1'b1;
          end else begin
            err_onehot_d = 1'b1;
            err_pulse_d  = 1'b1;
          end
        end
        TRACK: begin
          if (!is_onehot) begin
            err_onehot_d = 1'b1;
            err_pulse_d  = 1'b1;
            state_d      = SEARCH;
          end else if (idx == pos) begin
            if (dcnt_q != DCNT_MAX) dcnt_d = dcnt_q + DCNT_ONE;
            if (dcnt_d == DCNT_MAX) begin
              err_dwell_d = 1'b1;
              err_pulse_d = 1'b1;
              state_d     = SEARCH;
            end
          end else if (idx == next_pos(pos, N_LEDS)) begin
            // A badly timed step is flagged but still followed.
            step_d  = 1'b1;
            pos_d   = idx;
            dcnt_d  = DCNT_ONE;
            first_d = 1'b0;
            if (!first_q && (dcnt_q != DCNT_DWELL)) begin
              err_dwell_d = 1'b1;
              err_pulse_d = 1'b1;
            end
            if ((pos == LAST_POS) && (lap_count != LAP_MAX)) begin
              lap_d = lap_count + LAP_W'(1);
            end
          end else begin
            err_order_d = 1'b1;
            err_pulse_d = 1'b1;
            state_d     = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    locked_d = (state_d == TRACK);
  end

  // State and output registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SEARCH;
      dcnt_q     <= '0;
      first_q    <= 1'b0;
      pos        <= '0;
      lap_count  <= '0;
      locked     <= 1'b0;
      step       <= 1'b0;
      err_pulse  <= 1'b0;
      err_onehot <= 1'b0;
      err_order  <= 1'b0;
      err_dwell  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      first_q    <= first_d;
      pos        <= pos_d;
      lap_count  <= lap_d;
      locked     <= locked_d;
      step       <= step_d;
      err_pulse  <= err_pulse_d;
      err_onehot <= err_onehot_d;
      err_order  <= err_order_d;
      err_dwell  <= err_dwell_d;
    end
  end

endmodule

// File: tb/tb_chase_monitor.sv
// Directed self-checking bench for chase_monitor (default and 2-bit lap counter).
module tb_chase_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [6:0] l = '0;

  logic [2:0] pos, pos_s;
  logic       locked, step, err_pulse, err_onehot, err_order, err_dwell;
  logic       locked_s, step_s, err_pulse_s, err_onehot_s, err_order_s, err_dwell_s;
  logic [7:0] lap_count;
  logic [1:0] lap_count_s;
  logic [5:0] fl;

  int tests = 0;
  int fails = 0;

  // {locked, step, err_pulse, err_onehot, err_order, err_dwell}
  assign fl = {locked, step, err_pulse, err_onehot, err_order, err_dwell};

  always #5 clk = ~clk;

  chase_monitor dut (
    .clk (clk), .reset (reset), .enable (enable), .l (l),
    .pos (pos), .locked (locked), .step (step), .lap_count (lap_count),
    .err_pulse (err_pulse), .err_onehot (err_onehot),
    .err_order (err_order), .err_dwell (err_dwell)
  );

  chase_monitor #(.LAP_W (2)) dut_s (
    .clk (clk), .reset (reset), .enable (enable), .l (l),
    .pos (pos_s), .locked (locked_s), .step (step_s), .lap_count (lap_count_s),
    .err_pulse (err_pulse_s), .err_onehot (err_onehot_s),
    .err_order (err_order_s), .err_dwell (err_dwell_s)
  );

  function automatic logic [6:0] lamp(input int p);
    return 7'(1 << p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] v);
    l = v;
    tick();
  endtask

  task automatic hold(input int p, input int n);
    for (int i = 0; i < n; i++) drive(lamp(p));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b1;
    l = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; l = '0;
    tick(); tick();
    tests++;
    if (fl !== 6'b000000 || pos !== 3'd0 || lap_count !== 8'd0 || lap_count_s !== 2'd0) begin
      fails++;
      $display("FAIL reset_state flags=%b pos=%0d lap=%0d lap_s=%0d want 000000/0/0/0", fl, pos, lap_count, lap_count_s);
    end
    enable = 1'b1;
    drive(lamp(2));
    tests++;
    if (fl !== 6'b000000 || pos !== 3'd0) begin
      fails++;
      $display("FAIL reset_priority flags=%b pos=%0d want 000000/0", fl, pos);
    end
    reset = 1'b0;
  endtask

  task automatic test_nominal();
    logic exp_step;
    for (int k = 0; k < 60; k++) begin
      drive(lamp((k / 4) % 6));
      exp_step = (k > 0) && (k % 4 == 0);
      tests++;
      if (fl !== {1'b1, exp_step, 4'b0000} || pos !== 3'((k / 4) % 6)) begin
        fails++;
        $display("FAIL nominal k=%0d flags=%b pos=%0d want %b/%0d", k, fl, pos, {1'b1, exp_step, 4'b0000}, (k / 4) % 6);
      end
    end
    tests++;
    if (lap_count !== 8'd2 || lap_count_s !== 2'd2) begin
      fails++;
      $display("FAIL nominal_laps lap=%0d lap_s=%0d want 2/2", lap_count, lap_count_s);
    end
  endtask

  task automatic test_early_step();
    do_reset();
    hold(1, 4);
    hold(2, 3);
    drive(lamp(3));
    tests++;
    if (fl !== 6'b111001 || pos !== 3'd3) begin
      fails++;
      $display("FAIL early_step flags=%b pos=%0d want 111001/3", fl, pos);
    end
    drive(lamp(3));
    tests++;
    if (fl !== 6'b100001 || pos !== 3'd3) begin
      fails++;
      $display("FAIL early_step_after flags=%b pos=%0d want 100001/3", fl, pos);
    end
  endtask

  task automatic test_stall();
    do_reset();
    hold(3, 4);
    hold(4, 4);
    tests++;
    if (fl !== 6'b100000 || pos !== 3'd4) begin
      fails++;
      $display("FAIL stall_4th flags=%b pos=%0d want 100000/4", fl, pos);
    end
    drive(lamp(4));
    tests++;
    if (fl !== 6'b001001) begin
      fails++;
      $display("FAIL stall_5th flags=%b want 001001", fl);
    end
    drive(lamp(4));
    tests++;
    if (fl !== 6'b100001 || pos !== 3'd4) begin
      fails++;
      $display("FAIL stall_relock flags=%b pos=%0d want 100001/4", fl, pos);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(7'b0000011);
    tests++;
    if (fl !== 6'b001100) begin
      fails++;
      $display("FAIL illegal_two_hot flags=%b want 001100", fl);
    end
    drive(lamp(0));
    tests++;
    if (fl !== 6'b100100 || pos !== 3'd0) begin
      fails++;
      $display("FAIL illegal_lock flags=%b pos=%0d want 100100/0", fl, pos);
    end
    drive(7'b1000001);
    tests++;
    if (fl !== 6'b001100) begin
      fails++;
      $display("FAIL illegal_top_bit flags=%b want 001100", fl);
    end
    drive(lamp(1));
    tests++;
    if (fl !== 6'b100100 || pos !== 3'd1) begin
      fails++;
      $display("FAIL illegal_relock flags=%b pos=%0d want 100100/1", fl, pos);
    end
    drive(lamp(3));
    tests++;
    if (fl !== 6'b001110) begin
      fails++;
      $display("FAIL order_jump flags=%b want 001110", fl);
    end
    drive(7'b0000000);
    tests++;
    if (fl !== 6'b001110) begin
      fails++;
      $display("FAIL dark_bus flags=%b want 001110", fl);
    end
  endtask

  task automatic test_enable_gating();
    do_reset();
    hold(0, 4);
    hold(1, 2);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(7'($urandom));
      tests++;
      if (fl !== 6'b100000 || pos !== 3'd1) begin
        fails++;
        $display("FAIL gated i=%0d flags=%b pos=%0d want 100000/1", i, fl, pos);
      end
    end
    enable = 1'b1;
    hold(1, 2);
    tests++;
    if (fl !== 6'b100000 || pos !== 3'd1) begin
      fails++;
      $display("FAIL gated_resume flags=%b pos=%0d want 100000/1", fl, pos);
    end
    drive(lamp(2));
    tests++;
    if (fl !== 6'b110000 || pos !== 3'd2) begin
      fails++;
      $display("FAIL gated_step flags=%b pos=%0d want 110000/2", fl, pos);
    end
  endtask

  task automatic test_wrap_dwell();
    do_reset();
    hold(4, 4);
    hold(5, 3);
    drive(lamp(0));
    tests++;
    if (fl !== 6'b111001 || pos !== 3'd0 || lap_count !== 8'd1 || lap_count_s !== 2'd1) begin
      fails++;
      $display("FAIL wrap_dwell flags=%b pos=%0d lap=%0d lap_s=%0d want 111001/0/1/1", fl, pos, lap_count, lap_count_s);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    drive(lamp(0));
    tests++;
    if (fl !== 6'b000000 || pos !== 3'd0 || lap_count !== 8'd0 || lap_count_s !== 2'd0) begin
      fails++;
      $display("FAIL reset_mid flags=%b pos=%0d lap=%0d lap_s=%0d want 000000/0/0/0", fl, pos, lap_count, lap_count_s);
    end
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    enable = 1'b1;
    for (int lp = 0; lp < 31; lp++) hold(lp % 6, 4);
    tests++;
    if (lap_count !== 8'd5 || lap_count_s !== 2'd3) begin
      fails++;
      $display("FAIL lap_saturation lap=%0d lap_s=%0d want 5/3", lap_count, lap_count_s);
    end
    tests++;
    if (fl !== 6'b100000 || pos !== 3'd0) begin
      fails++;
      $display("FAIL saturation_flags flags=%b pos=%0d want 100000/0", fl, pos);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_early_step();
    test_stall();
    test_illegal();
    test_enable_gating();
    test_wrap_dwell();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
